// File: rtl/ring_fire_scheduler_pkg.sv
// Shared types and default sizing for the ring fire scheduler.
package ring_sched_pkg;

    localparam int unsigned DEF_N     = 30;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2,
        DEADLOCK = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ring_fire_scheduler_if.sv
// Control/status bundle of the ring fire scheduler.
// The master side drives the controls; the slave side is the scheduler.
interface ring_fire_scheduler_if
    import ring_sched_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    localparam int unsigned IDX_W = $clog2(N);

    logic             start_i;
    logic             stop_i;
    logic             load_i;
    logic [N-1:0]     load_val_i;
    logic [N-1:0]     freeze_i;
    logic [CNT_W-1:0] target_i;

    logic [N-1:0]     state_o;
    logic [N-1:0]     excited_o;
    logic [N-1:0]     fire_o;
    logic [IDX_W-1:0] fire_idx_o;
    logic [CNT_W-1:0] lap_cnt_o;
    logic             busy_o;
    logic             done_o;
    logic             deadlock_o;

    modport master (
        output start_i, stop_i, load_i, load_val_i, freeze_i, target_i,
        input  state_o, excited_o, fire_o, fire_idx_o, lap_cnt_o,
               busy_o, done_o, deadlock_o
    );

    modport slave (
        input  start_i, stop_i, load_i, load_val_i, freeze_i, target_i,
        output state_o, excited_o, fire_o, fire_idx_o, lap_cnt_o,
               busy_o, done_o, deadlock_o
    );

endinterface

// File: rtl/ring_fire_scheduler_rr_arbiter.sv
// Round-robin picker: grants the first requester strictly after ptr,
// wrapping from N-1 back to 0 (ptr itself is searched last).
module rr_arbiter
    import ring_sched_pkg::*;
#(
    parameter  int unsigned N     = DEF_N,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic        found;
    int unsigned pos;

    // Scan positions ptr+1 .. ptr+N modulo N, keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ring_fire_scheduler.sv
// Ring fire scheduler: an N-signal ring where stage k drives signal
// n((k+1) mod N). Stage 0 inverts n0, the rest buffer nk. Each RUN cycle
// one excited, unfrozen stage fires (round-robin) and toggles its driven
// signal; n0 rising edges are counted as laps.
module ring_fire_scheduler
    import ring_sched_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  rst_n,
    ring_fire_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N);

    sched_state_t     fsm;
    logic [N-1:0]     ring;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] lap;

    logic [N-1:0]     excited;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     toggle;
    logic             fire_en;
    logic             lap_hit;
    logic [CNT_W-1:0] lap_inc;

    // Excitation: a stage is excited when its driven signal differs from
    // the value the stage would drive onto it.
    always_comb begin
        excited    = '0;
        excited[0] = (ring[1] == ring[0]);
        for (int unsigned k = 1; k < N; k++) begin
            excited[k] = (ring[(k + 1) % N] != ring[k]);
        end
    end

    assign req = excited & ~bus.freeze_i;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Fire qualification and the effect of the granted stage on the ring.
    always_comb begin
        fire_en = (fsm == RUN) && !bus.stop_i && (|req);
        // Granted stage k toggles n(k+1); stage N-1 wraps onto n0.
        toggle  = {grant[N-2:0], grant[N-1]};
        // Stage N-1 firing while n0 is low drives n0 0->1.
        lap_hit = grant[N-1] && !ring[0];
        lap_inc = lap + 1'b1;
    end

    // Scheduler FSM with ring state, round-robin pointer and lap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm  <= IDLE;
            ring <= '0;
            ptr  <= IDX_W'(N - 1);
            lap  <= '0;
        end else begin
            case (fsm)
                RUN: begin
                    if (bus.stop_i) begin
                        fsm <= IDLE;
                    end else if (!(|req)) begin
                        fsm <= DEADLOCK;
                    end else begin
                        ring <= ring ^ toggle;
                        ptr  <= grant_idx;
                        if (lap_hit && (lap != '1)) begin
                            lap <= lap_inc;
                            if ((bus.target_i != '0) && (lap_inc == bus.target_i)) begin
                                fsm <= DONE;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.load_i) begin
                        ring <= bus.load_val_i;
                    end
                    if (bus.start_i) begin
                        fsm <= RUN;
                        lap <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.state_o    = ring;
    assign bus.excited_o  = excited;
    assign bus.fire_o     = fire_en ? grant : '0;
    assign bus.fire_idx_o = fire_en ? grant_idx : '0;
    assign bus.lap_cnt_o  = lap;
    assign bus.busy_o     = (fsm == RUN);
    assign bus.done_o     = (fsm == DONE);
    assign bus.deadlock_o = (fsm == DEADLOCK);

endmodule

// File: tb/tb_ring_fire_scheduler.sv
// Directed bench for ring_fire_scheduler (N=30, CNT_W=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ring_fire_scheduler;

    localparam int unsigned N     = 30;
    localparam int unsigned CNT_W = 16;

    localparam logic [N-1:0] ALL_ONES = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   fires    = 0;

    ring_fire_scheduler_if #(.N(N), .CNT_W(CNT_W)) bus ();

    ring_fire_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.load_i     = 1'b0;
        bus.load_val_i = '0;
        bus.freeze_i   = '0;
        bus.target_i   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_state",    64'(bus.state_o),    64'h0);
        chk("rst_excited",  64'(bus.excited_o),  64'h1);
        chk("rst_fire",     64'(bus.fire_o),     64'h0);
        chk("rst_fire_idx", 64'(bus.fire_idx_o), 64'h0);
        chk("rst_lap",      64'(bus.lap_cnt_o),  64'h0);
        chk("rst_busy",     64'(bus.busy_o),     64'h0);
        chk("rst_done",     64'(bus.done_o),     64'h0);
        chk("rst_deadlock", 64'(bus.deadlock_o), 64'h0);

        // One lap, target 1: fires 0..29, then DONE
        bus.target_i = 16'd1;
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("t1_busy", 64'(bus.busy_o), 64'h1);
        for (int i = 0; i < 30; i++) begin
            chk("t1_fire_idx", 64'(bus.fire_idx_o), 64'(i));
            chk("t1_fire_onehot", 64'(bus.fire_o), 64'(1) << i);
            if (i == 29) begin
                chk("t1_not_done_yet", 64'(bus.done_o), 64'h0);
            end
            @(negedge clk);
        end
        chk("t1_done",  64'(bus.done_o),    64'h1);
        chk("t1_busy0", 64'(bus.busy_o),    64'h0);
        chk("t1_lap",   64'(bus.lap_cnt_o), 64'h1);
        chk("t1_state", 64'(bus.state_o),   64'(ALL_ONES));
        chk("t1_fire0", 64'(bus.fire_o),    64'h0);

        // Target 3: 150 fires, period 60
        do_reset();
        bus.target_i = 16'd3;
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 150; i++) begin
            chk("t3_fire_idx", 64'(bus.fire_idx_o), 64'(i % 30));
            if (i == 90) begin
                chk("t3_lap_mid", 64'(bus.lap_cnt_o), 64'h2);
            end
            if (i == 149) begin
                chk("t3_not_done_yet", 64'(bus.done_o), 64'h0);
            end
            @(negedge clk);
        end
        chk("t3_done",  64'(bus.done_o),    64'h1);
        chk("t3_lap",   64'(bus.lap_cnt_o), 64'h3);
        chk("t3_state", 64'(bus.state_o),   64'(ALL_ONES));

        // Load 0x5 together with start: load first, then RUN
        do_reset();
        bus.load_i     = 1'b1;
        bus.load_val_i = 30'h5;
        bus.start_i    = 1'b1;
        @(negedge clk);
        bus.load_i  = 1'b0;
        bus.start_i = 1'b0;
        chk("ld_state",    64'(bus.state_o),    64'h5);
        chk("ld_excited",  64'(bus.excited_o),  64'h2000_0006);
        chk("ld_fire_idx1", 64'(bus.fire_idx_o), 64'd1);
        @(negedge clk);
        chk("ld_state1",   64'(bus.state_o),    64'h1);
        chk("ld_fire_idx2", 64'(bus.fire_idx_o), 64'd29);
        @(negedge clk);
        chk("ld_state2",   64'(bus.state_o),    64'h0);
        chk("ld_excited2", 64'(bus.excited_o),  64'h1);
        chk("ld_lap",      64'(bus.lap_cnt_o),  64'h0);
        bus.stop_i = 1'b1;
        #1;
        chk("ld_stop_no_fire", 64'(bus.fire_o), 64'h0);
        @(negedge clk);
        bus.stop_i = 1'b0;
        chk("ld_idle",      64'(bus.busy_o), 64'h0);
        chk("ld_idle_fire", 64'(bus.fire_o), 64'h0);

        // Stop on the 10th RUN cycle with start held; load in RUN ignored
        do_reset();
        fires       = 0;
        bus.start_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            chk("sp_fire_idx", 64'(bus.fire_idx_o), 64'(i));
            if (bus.fire_o != '0) fires++;
            if (i == 4) begin
                bus.load_i     = 1'b1;
                bus.load_val_i = '1;
            end
            @(negedge clk);
        end
        bus.stop_i = 1'b1;
        #1;
        chk("sp_stop_no_fire", 64'(bus.fire_o), 64'h0);
        if (bus.fire_o != '0) fires++;
        @(negedge clk);
        chk("sp_busy",     64'(bus.busy_o),     64'h0);
        chk("sp_done",     64'(bus.done_o),     64'h0);
        chk("sp_deadlock", 64'(bus.deadlock_o), 64'h0);
        chk("sp_state",    64'(bus.state_o),    64'h3FE);
        chk("sp_fires",    64'(fires),          64'd9);
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.load_i  = 1'b0;
        @(negedge clk);
        chk("sp_idle_state", 64'(bus.state_o), 64'h3FE);
        chk("sp_idle_busy",  64'(bus.busy_o),  64'h0);
        bus.load_i     = 1'b1;
        bus.load_val_i = 30'hF;
        @(negedge clk);
        bus.load_i = 1'b0;
        chk("sp_idle_load", 64'(bus.state_o), 64'hF);

        // Freeze stage 0 from reset state: deadlock
        do_reset();
        bus.freeze_i = 30'h1;
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("dl_busy",  64'(bus.busy_o), 64'h1);
        chk("dl_fire",  64'(bus.fire_o), 64'h0);
        @(negedge clk);
        chk("dl_deadlock", 64'(bus.deadlock_o), 64'h1);
        chk("dl_busy0",    64'(bus.busy_o),     64'h0);
        chk("dl_fire0",    64'(bus.fire_o),     64'h0);
        chk("dl_state",    64'(bus.state_o),    64'h0);
        bus.freeze_i = '0;
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("dl_restart_busy", 64'(bus.busy_o),     64'h1);
        chk("dl_restart_idx",  64'(bus.fire_o),     64'h1);

        // Asynchronous reset in mid-run abandons the run
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_state", 64'(bus.state_o), 64'h0);
        chk("mr_busy",  64'(bus.busy_o),  64'h0);
        chk("mr_fire",  64'(bus.fire_o),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_post_fire", 64'(bus.fire_o), 64'h0);
            chk("mr_post_busy", 64'(bus.busy_o), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
